// File: rtl/cnn_pkg.sv
// Shared definitions for the reconfigurable CNN datapath.
// LANES       : number of parallel lanes a word carries.
// lane_idx_t  : index of one lane within a word.
// ser_state_t : control state of the lane serializer.
package cnn_pkg;
  localparam int LANES = 4;

  typedef logic [1:0] lane_idx_t;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ser_state_t;
endpackage

// File: rtl/serializer_ctrl.sv
// Control path of the lane serializer: FSM, lane counter and last-lane register.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   cfg_lanes    active lanes minus one, taken only when a word is captured
//   in_valid     upstream word valid
//   out_ready    downstream accepts the current beat
//   in_ready     a word can be captured this cycle
//   capture      a word is captured at the next rising edge (hold-register load)
//   out_valid    a serial beat is presented
//   out_last     current beat is the final active lane of the word
//   lane         current lane select
//   state        FSM state, exported for observation
//
// Handshake semantics (both sides): a transfer happens on a rising edge where
// valid and ready are both high; a valid source keeps its data stable until
// that edge.
module serializer_ctrl
  import cnn_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  lane_idx_t  cfg_lanes,
  input  logic       in_valid,
  input  logic       out_ready,
  output logic       in_ready,
  output logic       capture,
  output logic       out_valid,
  output logic       out_last,
  output lane_idx_t  lane,
  output ser_state_t state
);

  ser_state_t state_d;
  lane_idx_t  lane_d;
  lane_idx_t  last_idx;
  lane_idx_t  last_idx_d;
  logic       beat;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      lane     <= '0;
      last_idx <= '0;
    end else begin
      state    <= state_d;
      lane     <= lane_d;
      last_idx <= last_idx_d;
    end
  end

  always_comb begin
    state_d    = state;
    lane_d     = lane;
    last_idx_d = last_idx;

    out_valid  = (state == SHIFT);
    out_last   = out_valid && (lane == last_idx);
    beat       = out_valid && out_ready;
    // The last beat of a word frees the hold registers in the same cycle,
    // so a waiting word is taken with no bubble (out_ready -> in_ready path).
    in_ready   = (state == IDLE) || (beat && out_last);
    capture    = in_valid && in_ready;

    if (capture) begin
      state_d    = SHIFT;
      lane_d     = '0;
      last_idx_d = cfg_lanes;
    end else if (beat) begin
      if (out_last) begin
        state_d = IDLE;
        lane_d  = '0;
      end else begin
        lane_d = lane + 2'd1;
      end
    end
  end

endmodule

// File: rtl/lane_serializer.sv
// Parallel-to-serial stage: captures a four-lane word and emits its active
// lanes one per accepted beat, lane 0 first.
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   cfg_lanes               active lanes minus one, sampled at word capture
//   in_valid / in_ready     upstream word handshake
//   in_data_0 .. in_data_3  parallel lanes
//   out_valid / out_ready   downstream beat handshake
//   out_data                value of the current lane
//   out_lane                index of the current lane
//   out_last                current beat is the final active lane
module lane_serializer
  import cnn_pkg::*;
#(
  parameter int DataWidth = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [1:0]           cfg_lanes,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DataWidth-1:0] in_data_3,
  input  logic [DataWidth-1:0] in_data_2,
  input  logic [DataWidth-1:0] in_data_1,
  input  logic [DataWidth-1:0] in_data_0,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DataWidth-1:0] out_data,
  output logic [1:0]           out_lane,
  output logic                 out_last
);

  logic [DataWidth-1:0] hold [LANES];
  logic                 capture;
  lane_idx_t            lane;
  ser_state_t           state;

  serializer_ctrl u_ctrl (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_lanes (cfg_lanes),
    .in_valid  (in_valid),
    .out_ready (out_ready),
    .in_ready  (in_ready),
    .capture   (capture),
    .out_valid (out_valid),
    .out_last  (out_last),
    .lane      (lane),
    .state     (state)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LANES; i++) hold[i] <= '0;
    end else if (capture) begin
      hold[0] <= in_data_0;
      hold[1] <= in_data_1;
      hold[2] <= in_data_2;
      hold[3] <= in_data_3;
    end
  end

  // Output is forced to zero outside SHIFT so stale words never leak out.
  assign out_data = (state == SHIFT) ? hold[lane] : '0;
  assign out_lane = lane;

endmodule

// File: tb/tb_lane_serializer.sv
module tb_lane_serializer;
  localparam int DW = 8;
  localparam int W  = DW + 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [1:0]    cfg_lanes = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data_3 = '0, in_data_2 = '0, in_data_1 = '0, in_data_0 = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic [1:0]    out_lane;
  logic          out_last;

  lane_serializer #(.DataWidth(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_lanes (cfg_lanes),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data_3 (in_data_3),
    .in_data_2 (in_data_2),
    .in_data_1 (in_data_1),
    .in_data_0 (in_data_0),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_lane  (out_lane),
    .out_last  (out_last)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  int           beat_cyc[$];
  int           checks = 0;
  int           errors = 0;
  int           stall_cnt = 0;
  bit           rand_mode = 0;

  // random downstream backpressure
  always @(posedge clk) begin
    #1;
    if (rand_mode) out_ready = ($urandom_range(0, 3) != 0);
  end

  // ---------------- monitor ----------------
  logic [W-1:0] held;
  logic [W-1:0] got;
  logic [W-1:0] exp;
  bit           stalled = 0;
  bit           cap_prev = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      stalled  = 0;
      cap_prev = 0;
    end else begin
      got = {out_last, out_lane, out_data};
      if (cap_prev) begin
        checks++;
        if (!(out_valid === 1'b1 && out_lane === 2'd0)) begin
          errors++;
          $display("FAIL latency: out_valid=%b out_lane=%0d, required 1 / 0", out_valid, out_lane);
        end
      end
      if (stalled) begin
        checks++;
        if (got !== held) begin
          errors++;
          $display("FAIL stall_hold: got %h, required %h", got, held);
        end
      end
      checks++;
      if (in_ready !== (!out_valid || (out_ready && out_last))) begin
        errors++;
        $display("FAIL in_ready: got %b (out_valid=%b out_ready=%b out_last=%b)",
                 in_ready, out_valid, out_ready, out_last);
      end
      if (out_valid && out_ready) begin
        beat_cyc.push_back(cyc);
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_beat: got {last,lane,data}=%h, required none", got);
        end else begin
          exp = exp_q.pop_front();
          if (got !== exp) begin
            errors++;
            $display("FAIL beat: got {last,lane,data}=%h, required %h", got, exp);
          end
        end
      end
      if (out_valid && !out_ready) begin
        stalled = 1;
        held    = got;
        stall_cnt++;
      end else begin
        stalled = 0;
      end
      cap_prev = in_valid && in_ready;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_word(input logic [1:0] cfg, input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                           input logic [DW-1:0] d2, input logic [DW-1:0] d3);
    logic [DW-1:0] d[4];
    bit done;
    int n;
    d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
    cfg_lanes = cfg;
    in_data_0 = d0; in_data_1 = d1; in_data_2 = d2; in_data_3 = d3;
    in_valid  = 1'b1;
    done = 0;
    n = 0;
    while (!done && n < 200) begin
      @(negedge clk);
      if (in_ready && rst_n) begin
        // reference: lanes 0..cfg in order, last flag on lane cfg
        for (int i = 0; i <= int'(cfg); i++)
          exp_q.push_back({(i == int'(cfg)), 2'(i), d[i]});
        done = 1;
      end
      @(posedge clk);
      #1;
      n++;
    end
    in_valid  = 1'b0;
    // scramble inputs after capture: must not affect the word in flight
    cfg_lanes = 2'($urandom);
    in_data_0 = DW'($urandom); in_data_1 = DW'($urandom);
    in_data_2 = DW'($urandom); in_data_3 = DW'($urandom);
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: in_ready never seen, required capture within 200 cycles");
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (exp_q.size() != 0 || out_valid) begin
      errors++;
      $display("FAIL drain: %0d beats outstanding, required 0", exp_q.size());
    end
  endtask

  task automatic wait_lane1_beat(output bit ok);
    int n = 0;
    ok = 0;
    while (!ok && n < 50) begin
      @(negedge clk);
      if (out_valid && out_ready && out_lane == 2'd1) ok = 1;
      n++;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL lane1_timeout: lane 1 beat not seen, required within 50 cycles");
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    bit ok;
    int s0;
    int gap;

    // reset with random inputs
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid  = 1'($urandom);
      out_ready = 1'($urandom);
      cfg_lanes = 2'($urandom);
      in_data_0 = DW'($urandom); in_data_1 = DW'($urandom);
      in_data_2 = DW'($urandom); in_data_3 = DW'($urandom);
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || out_data !== '0 || in_ready !== 1'b1) begin
        errors++;
        $display("FAIL reset_state: out_valid=%b out_data=%h in_ready=%b, required 0/00/1",
                 out_valid, out_data, in_ready);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        errors++;
        $display("FAIL idle_after_reset: out_valid=%b in_ready=%b, required 0/1", out_valid, in_ready);
      end
    end
    @(posedge clk);
    #1;

    // full 4-lane word, consecutive beats
    beat_cyc.delete();
    send_word(2'd3, 8'h11, 8'h22, 8'h33, 8'h44);
    wait_drain();
    checks++;
    if (beat_cyc.size() != 4 || beat_cyc[3] - beat_cyc[0] != 3) begin
      errors++;
      $display("FAIL full_word_timing: %0d beats, required 4 consecutive", beat_cyc.size());
    end

    // narrow word, cfg changed mid-word (send_word scrambles cfg after capture)
    send_word(2'd1, 8'hA0, 8'hA1, 8'hA2, 8'hA3);
    cfg_lanes = 2'd3;
    wait_drain();

    // single-lane words
    send_word(2'd0, 8'h5A, 8'h00, 8'h00, 8'h00);
    send_word(2'd0, 8'hC3, 8'hFF, 8'hFF, 8'hFF);
    wait_drain();

    // backpressure on lane 2 for 3 cycles
    s0 = stall_cnt;
    fork
      send_word(2'd3, 8'h01, 8'h02, 8'h03, 8'h04);
      begin
        wait_lane1_beat(ok);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    wait_drain();
    checks++;
    if (stall_cnt - s0 != 3) begin
      errors++;
      $display("FAIL stall_cycles: got %0d, required 3", stall_cnt - s0);
    end

    // back-to-back 4-lane words
    beat_cyc.delete();
    send_word(2'd3, 8'h10, 8'h20, 8'h30, 8'h40);
    send_word(2'd3, 8'h50, 8'h60, 8'h70, 8'h80);
    wait_drain();
    checks++;
    if (beat_cyc.size() != 8 || beat_cyc[7] - beat_cyc[0] != 7) begin
      errors++;
      $display("FAIL back_to_back: %0d beats, required 8 in 8 consecutive cycles", beat_cyc.size());
    end

    // reset mid-word
    send_word(2'd3, 8'hE0, 8'hE1, 8'hE2, 8'hE3);
    wait_lane1_beat(ok);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== '0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_midword: out_valid=%b out_data=%h in_ready=%b, required 0/00/1",
               out_valid, out_data, in_ready);
    end
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send_word(2'd2, 8'h91, 8'h92, 8'h93, 8'h94);
    wait_drain();

    // randomized phase with random backpressure and gaps
    rand_mode = 1;
    for (int k = 0; k < 60; k++) begin
      send_word(2'($urandom), DW'($urandom), DW'($urandom), DW'($urandom), DW'($urandom));
      gap = $urandom_range(0, 2);
      repeat (gap) begin
        @(posedge clk);
        #1;
      end
    end
    wait_drain();
    rand_mode = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
